// File: rtl/seg_pkg.sv
// Shared definitions for the seg_counter_display slice: digit width,
// GFEDCBA segment codes (active-high) and the scan FSM state encoding.
package seg_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b1111100;
    localparam logic [6:0] SEG_C = 7'b0111001;
    localparam logic [6:0] SEG_D = 7'b1011110;
    localparam logic [6:0] SEG_E = 7'b1111001;
    localparam logic [6:0] SEG_F = 7'b1110001;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    function automatic logic [6:0] seg_decode(input logic [DIGIT_W-1:0] digit);
        logic [6:0] seg;
        case (digit)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, debounced
// level and a one-cycle pulse on each accepted press (1->0 of the level).
module key_debounce #(
    parameter int DEB_CYC = 250000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key,
    output logic key_fall
);

    localparam int CNT_W = $clog2(DEB_CYC);

    logic             key_meta;
    logic             key_sync;
    logic             key_level;
    logic             level_q;
    logic [CNT_W-1:0] stable_cnt;

    // NOTE: synchroniser flops reset to the released (high) level so that
    // coming out of reset never looks like a press.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make key_sync take the old
            // key_meta, which is what forms the two-stage pipeline.
            key_meta <= key;
            key_sync <= key_meta;
        end
    end

    // Any cycle where the input agrees with the level restarts the count.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stable_cnt <= '0;
            key_level  <= 1'b1;
            level_q    <= 1'b1;
        end else begin
            level_q <= key_level;
            if (key_sync == key_level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(DEB_CYC - 1)) begin
                stable_cnt <= '0;
                key_level  <= key_sync;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    assign key_fall = level_q & ~key_level;

endmodule

// File: rtl/seg_counter_display.sv
// N-digit hex/BCD up/down counter with a blanked, time-multiplexed 7-segment
// scan. Define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seg_counter_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 2097152,
    parameter int SCAN_DIV   = 65536,
    parameter int BLANK_CYC  = 256,
    parameter int DEB_CYC    = 250000,
    parameter int BCD        = 0
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          key,
    input  logic                          dir,
    output logic [2:0]                    led,
    output logic [6:0]                    ssegment,
    output logic [NUM_DIGITS-1:0]         scathod,
    output logic [DIGIT_W*NUM_DIGITS-1:0] count_val,
    output logic                          wrap
);

    localparam logic [DIGIT_W-1:0] DIGIT_MAX = (BCD != 0) ? 4'd9 : 4'd15;
    localparam int PRE_W    = $clog2(TICK_DIV);
    localparam int SCAN_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int SCAN_W   = (SCAN_MAX > 1) ? $clog2(SCAN_MAX) : 1;
    localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic                key_fall;
    logic                run;
    logic                led_press;
    logic                led_tick;
    logic [PRE_W-1:0]    presc;
    logic                tick;
    logic [DIGIT_W-1:0]  digit     [NUM_DIGITS];
    logic [DIGIT_W-1:0]  digit_nxt [NUM_DIGITS];
    logic                chain_carry;

    scan_state_t         state;
    scan_state_t         state_nxt;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [IDX_W-1:0]    idx;
    logic                lz_blank;
    logic [6:0]          seg_d;
    logic [NUM_DIGITS-1:0] cath_d;

    key_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_key_debounce (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key       (key),
        .key_fall  (key_fall)
    );

    assign tick = run && (presc == PRE_W'(TICK_DIV - 1));

    // Carry/borrow look-ahead: a digit moves only when every lower digit is
    // at its rollover value, so the whole chain settles in one cycle.
    always_comb begin
        // NOTE: blocking '=' here is deliberate; chain_carry must carry the
        // value computed for the previous digit within the same evaluation.
        chain_carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_nxt[i] = digit[i];
            if (dir) begin
                if (chain_carry)
                    digit_nxt[i] = (digit[i] == DIGIT_MAX) ? '0 : digit[i] + 1'b1;
                chain_carry = chain_carry & (digit[i] == DIGIT_MAX);
            end else begin
                if (chain_carry)
                    digit_nxt[i] = (digit[i] == '0) ? DIGIT_MAX : digit[i] - 1'b1;
                chain_carry = chain_carry & (digit[i] == '0);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            run       <= 1'b1;
            led_press <= 1'b0;
            led_tick  <= 1'b0;
            presc     <= '0;
            wrap      <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= '0;
        end else begin
            wrap <= 1'b0;
            if (key_fall) begin
                run       <= ~run;
                led_press <= ~led_press;
            end
            if (run) presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                digit    <= digit_nxt;
                wrap     <= chain_carry;
                led_tick <= ~led_tick;
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_count
        assign count_val[g*DIGIT_W +: DIGIT_W] = digit[g];
    end

    assign led = {led_tick, led_press, run};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_BLANK;
            scan_cnt <= '0;
            idx      <= '0;
        end else begin
            state    <= state_nxt;
            scan_cnt <= (state_nxt != state) ? '0 : scan_cnt + 1'b1;
            if (state == ST_SHOW && state_nxt == ST_BLANK)
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    always_comb begin
        // NOTE: default first; without it the paths that keep the state
        // would infer a latch.
        state_nxt = state;
        case (state)
            ST_BLANK: if (scan_cnt == SCAN_W'(BLANK_CYC - 1)) state_nxt = ST_SHOW;
            ST_SHOW:  if (scan_cnt == SCAN_W'(SCAN_DIV - 1))  state_nxt = ST_BLANK;
            default:  state_nxt = ST_BLANK;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] zero_above;

    // zero_above[i]: digit i and every higher digit are zero.
    always_comb begin
        zero_above[NUM_DIGITS-1] = (digit[NUM_DIGITS-1] == '0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--)
            zero_above[i] = zero_above[i+1] & (digit[i] == '0);
    end

    assign lz_blank = (idx != '0) && zero_above[idx];
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        seg_d  = '0;
        cath_d = '1;
        if (state == ST_SHOW && !lz_blank) begin
            seg_d       = seg_decode(digit[idx]);
            cath_d[idx] = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ssegment <= '0;
            scathod  <= '1;
        end else begin
            ssegment <= seg_d;
            scathod  <= cath_d;
        end
    end

endmodule

// File: tb/tb_seg_counter_display.sv
// Directed bench for seg_counter_display: one hex and one BCD instance share
// stimulus; expected values are hand-computed constants.
module tb_seg_counter_display;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        key       = 1'b1;
    logic        dir       = 1'b1;

    logic [2:0]  led_h, led_b;
    logic [6:0]  seg_h, seg_b;
    logic [2:0]  cath_h, cath_b;
    logic [11:0] cnt_h, cnt_b;
    logic        wrap_h, wrap_b;

    int errors = 0;
    int checks = 0;
    int wraps_h = 0;
    int wraps_b = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [2:0] D2_CATH = 3'b111;
    localparam logic [6:0] D2_SEG  = 7'b0000000;
`else
    localparam logic [2:0] D2_CATH = 3'b011;
    localparam logic [6:0] D2_SEG  = 7'b0111111;
`endif

    // One scan frame starting at the first SHOW cycle of digit 0, count 0A5.
    logic [2:0] exp_cath [16];
    logic [6:0] exp_seg  [16];

    always #5 sys_clk = ~sys_clk;

    seg_counter_display #(
        .NUM_DIGITS(3), .TICK_DIV(4), .SCAN_DIV(3), .BLANK_CYC(1), .DEB_CYC(3), .BCD(0)
    ) u_hex (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key), .dir(dir),
        .led(led_h), .ssegment(seg_h), .scathod(cath_h), .count_val(cnt_h), .wrap(wrap_h)
    );

    seg_counter_display #(
        .NUM_DIGITS(3), .TICK_DIV(4), .SCAN_DIV(3), .BLANK_CYC(1), .DEB_CYC(3), .BCD(1)
    ) u_bcd (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key), .dir(dir),
        .led(led_b), .ssegment(seg_b), .scathod(cath_b), .count_val(cnt_b), .wrap(wrap_b)
    );

    always @(negedge sys_clk) begin
        if (wrap_h === 1'b1) wraps_h <= wraps_h + 1;
        if (wrap_b === 1'b1) wraps_b <= wraps_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns on the first negedge after a count update (led[2] toggles).
    task automatic step_tick();
        logic prev;
        bit   seen;
        prev = led_h[2];
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge sys_clk);
            if (led_h[2] !== prev) seen = 1'b1;
        end
        check("tick_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_run(input logic val, input string tag);
        for (int c = 0; c < 30 && led_h[0] !== val; c++) @(negedge sys_clk);
        check(tag, 32'(led_h[0]), 32'(val));
    endtask

    task automatic check_counts(input string tag, input logic [11:0] eh, input logic [11:0] eb);
        check({tag, "_hex"}, 32'(cnt_h), 32'(eh));
        check({tag, "_bcd"}, 32'(cnt_b), 32'(eb));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] prev;
        bit found;

        exp_cath = '{3'b110, 3'b110, 3'b110, 3'b111, 3'b101, 3'b101, 3'b101, 3'b111,
                     D2_CATH, D2_CATH, D2_CATH, 3'b111, 3'b110, 3'b110, 3'b110, 3'b111};
        exp_seg  = '{7'b1101101, 7'b1101101, 7'b1101101, 7'b0,
                     7'b1110111, 7'b1110111, 7'b1110111, 7'b0,
                     D2_SEG, D2_SEG, D2_SEG, 7'b0,
                     7'b1101101, 7'b1101101, 7'b1101101, 7'b0};

        // Reset values.
        #1 sys_rst_n = 1'b0;
        #1;
        check_counts("rst_cnt", 12'h000, 12'h000);
        check("rst_led_h", 32'(led_h), 32'b001);
        check("rst_led_b", 32'(led_b), 32'b001);
        check("rst_seg_h", 32'(seg_h), 32'd0);
        check("rst_seg_b", 32'(seg_b), 32'd0);
        check("rst_cath_h", 32'(cath_h), 32'b111);
        check("rst_cath_b", 32'(cath_b), 32'b111);
        check("rst_wrap_h", 32'(wrap_h), 32'd0);
        check("rst_wrap_b", 32'(wrap_b), 32'd0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // 12 cycles up: ticks at cycles 4, 8, 12.
        repeat (12) @(posedge sys_clk);
        @(negedge sys_clk);
        check_counts("up12", 12'h003, 12'h003);
        check("up12_led", 32'(led_h), 32'b101);
        check("up12_wraps", 32'(wraps_h), 32'd0);

        // Down to zero, then wrap down, then wrap up.
        dir = 1'b0;
        repeat (3) step_tick();
        check_counts("down0", 12'h000, 12'h000);
        check("down0_wraps", 32'(wraps_h), 32'd0);
        step_tick();
        check_counts("wrap_dn", 12'hFFF, 12'h999);
        check("wrap_dn_h", 32'(wrap_h), 32'd1);
        check("wrap_dn_b", 32'(wrap_b), 32'd1);
        @(negedge sys_clk);
        check("wrap_dn_end_h", 32'(wrap_h), 32'd0);
        check("wrap_dn_end_b", 32'(wrap_b), 32'd0);
        dir = 1'b1;
        step_tick();
        check_counts("wrap_up", 12'h000, 12'h000);
        check("wrap_up_h", 32'(wrap_h), 32'd1);
        check("wrap_up_b", 32'(wrap_b), 32'd1);

        // BCD digit carry / borrow.
        repeat (99) step_tick();
        check_counts("cnt99", 12'h063, 12'h099);
        step_tick();
        check_counts("cnt100", 12'h064, 12'h100);
        dir = 1'b0;
        step_tick();
        check_counts("back99", 12'h063, 12'h099);
        check("wraps_h", 32'(wraps_h), 32'd2);
        check("wraps_b", 32'(wraps_b), 32'd2);
        dir = 1'b1;

        // Bouncy press right after an update: three more ticks before pause.
        key = 1'b0; repeat (2) @(negedge sys_clk);
        key = 1'b1; repeat (2) @(negedge sys_clk);
        key = 1'b0; repeat (2) @(negedge sys_clk);
        key = 1'b1; repeat (2) @(negedge sys_clk);
        key = 1'b0;
        wait_run(1'b0, "pause_run");
        check_counts("pause", 12'h066, 12'h102);
        check("pause_led1", 32'(led_h[1]), 32'd1);
        repeat (40) @(negedge sys_clk);
        check_counts("pause40", 12'h066, 12'h102);
        check("pause40_led", 32'(led_h), 32'b010);

        // Release has no effect; a clean press resumes.
        key = 1'b1;
        repeat (10) @(negedge sys_clk);
        check("release_led", 32'(led_h), 32'b010);
        key = 1'b0;
        wait_run(1'b1, "resume_run");
        check("resume_led", 32'(led_h), 32'b001);
        key = 1'b1;
        step_tick();
        check_counts("resume", 12'h067, 12'h103);

        // Count to 0A4, press right after that update: pauses at 0A5.
        repeat (61) step_tick();
        check_counts("cntA4", 12'h0A4, 12'h164);
        key = 1'b0;
        wait_run(1'b0, "pauseA5_run");
        check_counts("pauseA5", 12'h0A5, 12'h165);
        key = 1'b1;

        // Scan frame.
        prev  = cath_h;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge sys_clk);
            if (prev == 3'b111 && cath_h == 3'b110) found = 1'b1;
            prev = cath_h;
        end
        check("scan_sync", 32'(found), 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge sys_clk);
            check($sformatf("scan_cath%0d", i), 32'(cath_h), 32'(exp_cath[i]));
            check($sformatf("scan_seg%0d", i), 32'(seg_h), 32'(exp_seg[i]));
        end

        // Asynchronous reset mid-SHOW and mid-debounce.
        prev  = cath_h;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge sys_clk);
            if (prev == 3'b111 && cath_h != 3'b111) found = 1'b1;
            prev = cath_h;
        end
        check("show_seen", 32'(found), 32'd1);
        key = 1'b0;
        repeat (2) @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        check_counts("arst_cnt", 12'h000, 12'h000);
        check("arst_led", 32'(led_h), 32'b001);
        check("arst_seg", 32'(seg_h), 32'd0);
        check("arst_cath", 32'(cath_h), 32'b111);
        check("arst_wrap", 32'(wrap_h), 32'd0);
        key = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (12) @(posedge sys_clk);
        @(negedge sys_clk);
        check_counts("restart", 12'h003, 12'h003);
        check("restart_led", 32'(led_h), 32'b101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_counter_display.md
Name: seg_counter_display

Overview:
- Parametrised N-digit up/down counter with a time-multiplexed 7-segment display driver for the board's common-cathode digit array.
- A prescaled tick advances a cascaded hex or BCD digit chain.
- A debounced push-button toggles run/pause.
- A scan FSM with an inter-digit blanking phase drives segments and cathodes without ghosting.

Parameters:
- NUM_DIGITS, 4: number of display digits (1..8); digit 0 is least significant.
- TICK_DIV, 2097152: sys_clk cycles per count tick (>=2).
- SCAN_DIV, 65536: cycles each digit is shown (>=2).
- BLANK_CYC, 256: cycles all cathodes are off between digits (>=1).
- DEB_CYC, 250000: cycles the key input must be stable to be accepted (>=2).
- BCD, 0: 0 = hex digits 0..F; 1 = decimal digits 0..9.

Ports:
- sys_clk, input, 1: system clock.
- sys_rst_n, input, 1: asynchronous active-low reset.
- key, input, 1: raw push-button, active-low, asynchronous to sys_clk.
- dir, input, 1: count direction, 1 = up, 0 = down; sampled on each tick.
- led, output, 3: [0] run status, [1] toggles per accepted press, [2] toggles per tick.
- ssegment, output, 7: segment drive GFEDCBA, active-high.
- scathod, output, NUM_DIGITS: digit select, active-low; bit i selects digit i.
- count_val, output, 4*NUM_DIGITS: current digit chain, digit i at bits [4i+3:4i].
- wrap, output, 1: one-cycle pulse when the chain wraps in either direction.

Behaviour:
- Reset (async, sys_rst_n=0): all digits 0, run=1, led=3'b001, ssegment=0, scathod all 1s, wrap=0, prescaler=0, scan index=0, scan state BLANK, debounced key=1. All outputs take these values immediately, mid-operation included.
- Key path:
  - 2-FF synchroniser, then key_debounce.
  - The debounced level updates only after the synchronised input has differed from it for DEB_CYC consecutive cycles; any bounce restarts the count.
  - A 1->0 transition of the debounced level toggles run and led[1] on the next cycle.
  - Release does nothing.
- Prescaler:
  - Counts 0..TICK_DIV-1 while run=1 and holds its value while run=0.
  - tick asserts for one cycle when the prescaler is at TICK_DIV-1; the prescaler then returns to 0.
  - If a press toggles run in the same cycle as a tick, the tick still takes effect (it uses the pre-toggle run).
- Digit chain, on tick:
  - Up: digit i increments iff every lower digit is at max (F, or 9 when BCD=1); a digit at max rolls to 0.
  - Down: digit i decrements iff every lower digit is 0; a digit at 0 rolls to max.
  - Every digit is updated in the same cycle; there is no ripple delay.
- Wrap:
  - Pulses one cycle with the update when the chain goes all-max->all-0 (up) or all-0->all-max (down).
  - led[2] toggles every tick.
- BCD=1: digits never hold values above 9.
- Scan FSM, states BLANK and SHOW:
  - BLANK: ssegment=0 and scathod all 1s for BLANK_CYC cycles, then go to SHOW.
  - SHOW: scathod[idx]=0, ssegment=decode(digit[idx]) for SCAN_DIV cycles. On exit, idx = (idx==NUM_DIGITS-1) ? 0 : idx+1, then go to BLANK.
  - The segments shown reflect the live digit value, so a mid-SHOW count change updates the display immediately.
- Decode, GFEDCBA: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- ssegment and scathod are registered outputs; there is 1 cycle from FSM state to pins.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: during SHOW, digit idx>0 keeps its cathode high and ssegment=0 when digit idx and all higher digits are 0. Digit 0 is always displayed. Scan timing is unchanged.
- Undefined: every digit is always displayed, leading zeros included.

Decomposition:
- Package seg_pkg:
  - SEG_* 7-bit decode constants.
  - scan state encoding (ST_BLANK, ST_SHOW).
  - DIGIT_W=4.
  - function seg_decode(4-bit)->7-bit.
- Sub-module key_debounce (sys_clk, sys_rst_n, DEB_CYC): synchroniser, stability counter, debounced level, and a one-cycle falling-edge pulse.

Test Plan (sim parameters: NUM_DIGITS=3, TICK_DIV=4, SCAN_DIV=3, BLANK_CYC=1, DEB_CYC=3):
- Reset, then run 12 cycles with dir=1 -> count_val 12'h003, led[2]=1, wrap never asserted.
- Preload via ticks to 12'hFFF, dir=1, one more tick -> count_val 12'h000 and wrap high exactly 1 cycle. Repeat with dir=0 from 12'h000 -> 12'hFFF and wrap pulses.
- BCD=1, dir=1, from 12'h099 one tick -> 12'h100; from 12'h999 -> 12'h000 with wrap. dir=0 from 12'h100 -> 12'h099.
- key bounces 1-0-1-0 every 2 cycles, then holds 0 -> exactly one run toggle (led[0] 1->0); prescaler frozen and count_val constant for 40 cycles; a second clean press resumes counting.
- Scan check: scathod sequence 111,110,111,101,111,011,111,110… with SHOW durations of 3 cycles and BLANK durations of 1 cycle; ssegment=0 whenever scathod is all 1s; count 12'h0A5 shows 1101101 on digit 0, 1110111 on digit 1, and 0111111 on digit 2 (blanked if LEADING_ZERO_BLANK_EN).
- Assert sys_rst_n low mid-SHOW and mid-debounce -> outputs take their reset values in the same cycle, asynchronously; after release, counting restarts from 0 with run=1.
